// File: rtl/uart_stim_tx.sv
// uart_stim_tx: bench-side UART transmitter feeding the SoC UART0 RX pin.
// Bytes pushed through a valid/ready port are queued in a small FIFO and
// serialised LSB first as 8N1/8N2, or 8E1/8E2 when UART_STIM_TX_PARITY_EN
// is defined.
// Ports:
//   cpu_clock   sole clock, rising edge
//   cpu_rst_n   asynchronous active-low reset
//   wr_valid    byte offered on wr_data
//   wr_ready    FIFO can accept (registered, from the queued count only)
//   wr_data     byte to send
//   tx          serial line, idle high
//   busy        frame in progress or FIFO non-empty
//   fifo_count  bytes queued, excluding the byte on the wire
module uart_stim_tx #(
    parameter int unsigned CLKS_PER_BIT = 564,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                        cpu_clock,
    input  logic                        cpu_rst_n,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [7:0]                  wr_data,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

    // Parameter legality
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_stim_tx: CLKS_PER_BIT must be >= 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_stim_tx: STOP_BITS must be 1 or 2");
    end
    if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 256) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_stim_tx: FIFO_DEPTH must be a power of two in 2..256");
    end

`ifdef UART_STIM_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t          state;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_cnt;
    logic            stop_cnt;
    logic [7:0]      shift;
`ifdef UART_STIM_TX_PARITY_EN
    logic            par_bit;
`endif

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count_next;
    logic [7:0]      head;
    logic            push;
    logic            pop;
    logic            bit_end;
    logic            stop_last;

    // Handshake, pop decision and next queued count
    always_comb begin
        bit_end    = (timer == TW'(CLKS_PER_BIT - 1));
        stop_last  = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
        push       = wr_valid && wr_ready;
        pop        = (fifo_count != '0) &&
                     ((state == S_IDLE) || ((state == S_STOP) && bit_end && stop_last));
        head       = mem[rptr];
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CW'(1);
        end else if (!push && pop) begin
            count_next = fifo_count - CW'(1);
        end
    end

    // FIFO storage (no reset needed; validity tracked by the pointers)
    always_ff @(posedge cpu_clock) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    // FIFO pointers and count; power-of-two depth wraps naturally
    always_ff @(posedge cpu_clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            wr_ready   <= 1'b1;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            fifo_count <= count_next;
            wr_ready   <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    // Frame FSM; busy is registered from next state and next count
    always_ff @(posedge cpu_clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state    <= S_IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
`ifdef UART_STIM_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            busy <= 1'b1;
            case (state)
                S_IDLE: begin
                    tx   <= 1'b1;
                    busy <= (count_next != '0);
                end
                S_START: begin
                    if (bit_end) begin
                        timer <= '0;
                        state <= S_DATA;
                        tx    <= shift[0];
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_STIM_TX_PARITY_EN
                            state <= S_PARITY;
                            tx    <= par_bit;
`else
                            state    <= S_STOP;
                            stop_cnt <= 1'b0;
                            tx       <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
`ifdef UART_STIM_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        timer    <= '0;
                        state    <= S_STOP;
                        stop_cnt <= 1'b0;
                        tx       <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (stop_last) begin
                            state <= S_IDLE;
                            busy  <= (count_next != '0);
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
            // A pop always starts a new frame, from IDLE or straight out of STOP
            if (pop) begin
                shift   <= head;
`ifdef UART_STIM_TX_PARITY_EN
                par_bit <= ^head;
`endif
                timer   <= '0;
                bit_cnt <= '0;
                tx      <= 1'b0;
                state   <= S_START;
                busy    <= 1'b1;
            end
        end
    end

endmodule
